// File: rtl/block_transfer_seq.sv
// LDM/STM block-transfer sequencer: walks a register list lowest-first, one memory beat per register.
// Optional abort on memory error is compiled in with `define BLOCK_TRANSFER_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | pick lowest pending register, launch its memory beat
// XFER  | beat outstanding until mem_ready
// WB    | optional base-register writeback
// DONE  | one-cycle completion pulse
module block_transfer_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_list,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
`ifdef BLOCK_TRANSFER_ABORT_EN
    input  logic              mem_err,
    output logic              aborted,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int KW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);
    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_XFER, S_WB, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   mask_q;
    logic [ADDR_W-1:0] cur_addr_q, final_addr_q;
    logic              is_load_q, wback_q, base_in_list_q, mem_we_q;
    logic [3:0]        base_reg_q;
    logic [KW-1:0]     k_q, k_sel;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [CW-1:0]     n_cnt;
    logic [ADDR_W-1:0] span, start_addr, fin_addr;
    logic              beat_err;
    logic              beat_ok;

`ifdef BLOCK_TRANSFER_ABORT_EN
    logic aborted_q;
    assign beat_err = mem_err;
    assign aborted  = (state_q == S_DONE) && aborted_q;
`else
    assign beat_err = 1'b0;
`endif

    assign beat_ok   = mem_ready && !beat_err;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Lowest transferred register always sits at the lowest address.
    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            n_cnt = n_cnt + CW'(reg_list[i]);
        end
        span = ADDR_W'(n_cnt) << 2;
        if (up) begin
            start_addr = pre ? base_addr + WORD : base_addr;
            fin_addr   = base_addr + span;
        end else begin
            start_addr = pre ? base_addr - span : base_addr - span + WORD;
            fin_addr   = base_addr - span;
        end
    end

    always_comb begin
        k_sel = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) k_sel = KW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        rf_ra   = '0;
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        pc_we   = 1'b0;
        pc_wd   = '0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (mask_q == '0) begin
                    state_d = S_WB;
                end else begin
                    rf_ra   = 5'(k_sel);
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                mem_req = 1'b1;
                mem_we  = mem_we_q;
                if (mem_ready) begin
                    if (beat_err) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        if (is_load_q && k_q == KW'(15)) begin
                            pc_we = 1'b1;
                            pc_wd = mem_rdata;
                        end else if (is_load_q) begin
                            rf_we = 1'b1;
                            rf_wa = 5'(k_q);
                            rf_wd = mem_rdata;
                        end
                    end
                end
            end
            S_WB: begin
                // A base register reloaded by LDM keeps the loaded value.
                if (wback_q && !(is_load_q && base_in_list_q)) begin
                    rf_we = 1'b1;
                    rf_wa = {1'b0, base_reg_q};
                    rf_wd = DATA_W'(final_addr_q);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q         <= '0;
            cur_addr_q     <= '0;
            final_addr_q   <= '0;
            is_load_q      <= 1'b0;
            wback_q        <= 1'b0;
            base_in_list_q <= 1'b0;
            base_reg_q     <= '0;
            k_q            <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
`ifdef BLOCK_TRANSFER_ABORT_EN
            aborted_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q         <= reg_list;
                        cur_addr_q     <= start_addr;
                        final_addr_q   <= fin_addr;
                        is_load_q      <= is_load;
                        wback_q        <= wback;
                        base_reg_q     <= base_reg;
                        base_in_list_q <= reg_list[base_reg];
`ifdef BLOCK_TRANSFER_ABORT_EN
                        aborted_q      <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
                    if (mask_q != '0) begin
                        k_q         <= k_sel;
                        mem_addr_q  <= cur_addr_q;
                        mem_wdata_q <= rf_rd;
                        mem_we_q    <= !is_load_q;
                    end
                end
                S_XFER: begin
                    if (beat_ok) begin
                        mask_q[k_q] <= 1'b0;
                        cur_addr_q  <= cur_addr_q + WORD;
                    end else if (mem_ready) begin
                        mask_q <= '0;
`ifdef BLOCK_TRANSFER_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_transfer_seq.sv
// Bench for block_transfer_seq: directed vector table, reset corner case and randomized
// transfers checked against an address/ordering model of LDM/STM semantics.
module tb_block_transfer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_load, up, pre, wback;
    logic [3:0]  base_reg;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic        busy, done;
    logic [4:0]  rf_ra, rf_wa;
    logic [31:0] rf_rd, rf_wd, pc_wd, mem_addr, mem_wdata, mem_rdata;
    logic        rf_we, pc_we, mem_req, mem_we, mem_ready;
`ifdef BLOCK_TRANSFER_ABORT_EN
    logic        mem_err = 1'b0;
    logic        aborted;
`endif

    logic [31:0] regs [32];
    assign rf_rd = regs[rf_ra];

    always #5 clk = ~clk;

    block_transfer_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up), .pre(pre),
        .wback(wback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
        .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
`ifdef BLOCK_TRANSFER_ABORT_EN
        .mem_err(mem_err), .aborted(aborted),
`endif
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } beat_t;
    typedef struct { logic [4:0] wa; logic [31:0] wd; } wr_t;

    beat_t       obs_beats[$];
    wr_t         obs_rf[$];
    logic [31:0] obs_pc[$];
    int          obs_done, obs_waits;

    int          cfg_wait_idx, cfg_wait_len;
    bit          cfg_rand_wait, cfg_fixed_en, cfg_noise;
    logic [31:0] cfg_fixed, salt;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return cfg_fixed_en ? cfg_fixed : ({a[15:0], ~a[15:0]} ^ salt);
    endfunction

    function automatic int pick_wait(input int idx);
        if (cfg_rand_wait) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        return (idx == cfg_wait_idx) ? cfg_wait_len : 0;
    endfunction

    task automatic run_txn(input bit ld, input bit up_i, input bit pre_i, input bit wb_i,
                           input logic [3:0] br, input logic [31:0] base, input logic [15:0] list);
        beat_t       exp_beats[$];
        wr_t         exp_rf[$];
        logic [31:0] exp_pc[$];
        logic [31:0] snap [16];
        logic [31:0] lo, fin, a, n4;
        int          n, beat_idx, wait_left, cyc;
        bit          prev_stall, finished, wr_en;
        beat_t       prev;
        wr_t         wr;

        regs[br] = base;
        for (int i = 0; i < 16; i++) snap[i] = regs[i];
        n   = $countones(list);
        n4  = 32'(n * 4);
        lo  = up_i ? base + (pre_i ? 32'd4 : 32'd0) : base - n4 + (pre_i ? 32'd0 : 32'd4);
        fin = up_i ? base + n4 : base - n4;
        a   = lo;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_beats.push_back('{a, !ld, ld ? 32'd0 : snap[i]});
                if (ld && i == 15) exp_pc.push_back(rdata_of(a));
                else if (ld) exp_rf.push_back('{5'(i), rdata_of(a)});
                a = a + 32'd4;
            end
        end
        if (wb_i && !(ld && list[br])) exp_rf.push_back('{{1'b0, br}, fin});

        obs_beats.delete(); obs_rf.delete(); obs_pc.delete();
        obs_done = -1; obs_waits = 0;

        @(negedge clk);
        is_load = ld; up = up_i; pre = pre_i; wback = wb_i;
        base_reg = br; base_addr = base; reg_list = list; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; beat_idx = 0; wait_left = pick_wait(0); prev_stall = 0; finished = 0;
        while (!finished && cyc < 400) begin
            if (cfg_noise && cyc == 1) begin
                start = 1'b1; reg_list = 16'hFFFF; is_load = ~ld;
            end else begin
                start = 1'b0;
            end
            if (mem_req) mem_ready = (wait_left == 0);
            else mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = rdata_of(mem_addr);
            #1;
            if (prev_stall) begin
                chk("stall_req", mem_req, 1);
                chk("stall_addr", mem_addr, prev.addr);
                chk("stall_we", mem_we, prev.we);
                chk("stall_wdata", mem_wdata, prev.data);
            end
            if (mem_req && mem_ready) begin
                obs_beats.push_back('{mem_addr, mem_we, mem_we ? mem_wdata : 32'd0});
                beat_idx++;
                wait_left = pick_wait(beat_idx);
                prev_stall = 0;
            end else if (mem_req) begin
                prev = '{mem_addr, mem_we, mem_wdata};
                prev_stall = 1;
                wait_left--;
                obs_waits++;
            end else begin
                prev_stall = 0;
            end
            wr_en = rf_we;
            wr = '{rf_wa, rf_wd};
            if (rf_we) obs_rf.push_back(wr);
            if (pc_we) obs_pc.push_back(pc_wd);
            chk("busy_during", busy, 1);
            if (done) begin
                obs_done = cyc;
                finished = 1;
            end
            @(posedge clk); #1;
            if (wr_en) regs[wr.wa] = wr.wd;
            cyc++;
        end
        start = 1'b0;
        mem_ready = 1'b0;
        if (!finished) chk("done_timeout", 0, 1);
        chk("busy_after", busy, 0);
        chk("req_after", mem_req, 0);

        chk("beat_cnt", obs_beats.size(), exp_beats.size());
        for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
            chk("beat_addr", obs_beats[i].addr, exp_beats[i].addr);
            chk("beat_we", obs_beats[i].we, exp_beats[i].we);
            if (!ld) chk("beat_wdata", obs_beats[i].data, exp_beats[i].data);
        end
        chk("rf_cnt", obs_rf.size(), exp_rf.size());
        for (int i = 0; i < exp_rf.size() && i < obs_rf.size(); i++) begin
            chk("rf_wa", obs_rf[i].wa, exp_rf[i].wa);
            chk("rf_wd", obs_rf[i].wd, exp_rf[i].wd);
        end
        chk("pc_cnt", obs_pc.size(), exp_pc.size());
        for (int i = 0; i < exp_pc.size() && i < obs_pc.size(); i++)
            chk("pc_wd", obs_pc[i], exp_pc[i]);
        chk("done_cycle", obs_done, 3 + 2 * n + obs_waits);
    endtask

    typedef struct {
        bit ld, up, pre, wb;
        logic [3:0] br;
        logic [31:0] base;
        logic [15:0] list;
        int wait_idx, wait_len;
        bit fixed_en;
        logic [31:0] fixed;
        bit noise;
        int exp_beats;
        logic [31:0] exp_first;
        int exp_rf_cnt;
        bit exp_wb;
        logic [31:0] exp_wb_val;
        int exp_pc;
        int exp_done;
    } vec_t;

    vec_t vecs [7];
    int   wa15;

    initial begin
        //          ld up pr wb br     base           list      wi wl fx fixval      nz bt first           rf wb wbval          pc done
        vecs[0] = '{1, 1, 0, 0, 4'd3,  32'h0000_0100, 16'h0006, -1, 0, 0, 32'h0,      0, 2, 32'h0000_0100, 2, 0, 32'h0,         0, 7};
        vecs[1] = '{0, 0, 1, 1, 4'd13, 32'h0000_0200, 16'h4010, -1, 0, 0, 32'h0,      0, 2, 32'h0000_01F8, 1, 1, 32'h0000_01F8, 0, 7};
        vecs[2] = '{1, 1, 1, 0, 4'd2,  32'h0000_0300, 16'h8001, -1, 0, 1, 32'h8000,   0, 2, 32'h0000_0304, 1, 0, 32'h0,         1, 7};
        vecs[3] = '{1, 1, 0, 0, 4'd5,  32'h0000_1000, 16'h000F,  1, 3, 0, 32'h0,      0, 4, 32'h0000_1000, 4, 0, 32'h0,         0, 14};
        vecs[4] = '{1, 1, 0, 1, 4'd2,  32'h0000_0040, 16'h0000, -1, 0, 0, 32'h0,      1, 0, 32'h0,         1, 1, 32'h0000_0040, 0, 3};
        vecs[5] = '{1, 0, 0, 1, 4'd0,  32'h0000_0500, 16'h0003, -1, 0, 0, 32'h0,      0, 2, 32'h0000_04FC, 2, 0, 32'h0,         0, 7};
        vecs[6] = '{0, 1, 0, 1, 4'd5,  32'hFFFF_FFF8, 16'h0007, -1, 0, 0, 32'h0,      0, 3, 32'hFFFF_FFF8, 1, 1, 32'h0000_0004, 0, 9};

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        start = 0; is_load = 0; up = 0; pre = 0; wback = 0; base_reg = 0;
        base_addr = 0; reg_list = 0; mem_ready = 0; mem_rdata = 0; salt = 32'h5A5A_1234;
        cfg_rand_wait = 0; cfg_fixed_en = 0; cfg_noise = 0; cfg_fixed = 0;
        cfg_wait_idx = -1; cfg_wait_len = 0;
        rst_n = 0;
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", {rf_we, pc_we, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rfwd", {rf_ra, rf_wa, rf_wd, pc_wd}, 0);
        @(negedge clk);
        rst_n = 1;

        for (int v = 0; v < 7; v++) begin
            cfg_wait_idx = vecs[v].wait_idx; cfg_wait_len = vecs[v].wait_len;
            cfg_fixed_en = vecs[v].fixed_en; cfg_fixed = vecs[v].fixed; cfg_noise = vecs[v].noise;
            run_txn(vecs[v].ld, vecs[v].up, vecs[v].pre, vecs[v].wb, vecs[v].br, vecs[v].base, vecs[v].list);
            chk("vec_beats", obs_beats.size(), vecs[v].exp_beats);
            if (vecs[v].exp_beats > 0 && obs_beats.size() > 0)
                chk("vec_first_addr", obs_beats[0].addr, vecs[v].exp_first);
            chk("vec_rf_cnt", obs_rf.size(), vecs[v].exp_rf_cnt);
            if (vecs[v].exp_wb) begin
                if (obs_rf.size() > 0) begin
                    chk("vec_wb_reg", obs_rf[$].wa, {1'b0, vecs[v].br});
                    chk("vec_wb_val", obs_rf[$].wd, vecs[v].exp_wb_val);
                end else begin
                    chk("vec_wb_missing", 0, 1);
                end
            end
            chk("vec_pc_cnt", obs_pc.size(), vecs[v].exp_pc);
            if (vecs[v].exp_pc > 0 && obs_pc.size() > 0) chk("vec_pc_val", obs_pc[0], vecs[v].fixed);
            wa15 = 0;
            foreach (obs_rf[j]) if (obs_rf[j].wa == 5'd15) wa15++;
            chk("vec_no_rf15", wa15, 0);
            chk("vec_done", obs_done, vecs[v].exp_done);
        end
        cfg_fixed_en = 0; cfg_noise = 0; cfg_wait_idx = -1;

        // Reset in the middle of a 4-register load, with a beat being completed.
        @(negedge clk);
        is_load = 1; up = 1; pre = 0; wback = 1; base_reg = 4'd7;
        base_addr = 32'h0000_0800; reg_list = 16'h00F0; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 10 && !mem_req; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_req_seen", mem_req, 1);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_mid_rfwe_pre", rf_we, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_rfwe", rf_we, 0);
        chk("rst_mid_pcwe", pc_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mem_addr, 0);
        mem_ready = 0;
        @(negedge clk);
        rst_n = 1;
        run_txn(1, 1, 0, 1, 4'd7, 32'h0000_0800, 16'h00F0);

        cfg_rand_wait = 1;
        for (int t = 0; t < 40; t++) begin
            salt = $urandom;
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)),
                    {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
